softmax_result_writer: RTL



---
 rtl/softmax_result_writer_if.sv | 31 +++
 rtl/softmax_result_writer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/softmax_result_writer_if.sv
// ---------------------------------------------------------------------------
// | Module : softmax_result_writer_if                                        |
// | Result stream in from softmax and write port out to on-chip memory.      |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

interface softmax_result_writer_if #(
  parameter int DATAWIDTH = 32,
  parameter int NUM       = 2,
  parameter int ADDRSIZE  = 9
);
  logic                      in_valid;
  logic [DATAWIDTH*NUM-1:0]  in_data;
  logic                      wr_ready;
  logic                      wr_en;
  logic [ADDRSIZE-1:0]       wr_addr;
  logic [DATAWIDTH*NUM-1:0]  wr_data;

  modport master (
    output in_valid, in_data, wr_ready,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, wr_ready,
    output wr_en, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/softmax_result_writer.sv
// ---------------------------------------------------------------------------
// | Module : softmax_result_writer                                           |
// | Buffers softmax result words in a skid FIFO and writes them to memory.   |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module softmax_result_writer #(
  parameter int DATAWIDTH  = 32,
  parameter int NUM        = 2,
  parameter int ADDRSIZE   = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 init,
  input  wire logic [ADDRSIZE-1:0]  start_addr,
  input  wire logic [ADDRSIZE-1:0]  end_addr,
  softmax_result_writer_if.slave    bus,
  output logic                      busy,
  output logic                      complete,
  output logic                      overflow
);

  localparam int WW = DATAWIDTH * NUM;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = ADDRSIZE + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state;
  logic [WW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [PW:0]         fifo_cnt;
  logic [ADDRSIZE-1:0] base;
  logic [ADDRSIZE-1:0] expected;
  logic [ADDRSIZE-1:0] hold_addr;
  logic [WW-1:0]       hold_data;
  logic [CW-1:0]       rx_cnt;
  logic [CW-1:0]       wr_cnt;

  logic                running;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                push;
  logic                drop;
  logic [ADDRSIZE-1:0] span;
  logic [ADDRSIZE-1:0] live_addr;

  assign span       = end_addr - start_addr;
  assign running    = (state == S_RUN);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
  assign live_addr  = base + wr_cnt[ADDRSIZE-1:0];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop  = running & ~fifo_empty & bus.wr_ready;
  assign push = running & bus.in_valid & (~fifo_full | pop) & (rx_cnt < {1'b0, expected});
  assign drop = running & bus.in_valid & ~push;

  assign bus.wr_en   = running & ~fifo_empty;
  assign bus.wr_addr = running ? live_addr : hold_addr;
  assign bus.wr_data = running ? fifo_mem[rd_ptr] : hold_data;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      base      <= '0;
      expected  <= '0;
      rx_cnt    <= '0;
      wr_cnt    <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      busy      <= 1'b0;
      complete  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      complete <= 1'b0;
      // Remember what was last presented so the port holds it outside RUN.
      if (running) begin
        hold_addr <= live_addr;
        hold_data <= fifo_mem[rd_ptr];
      end
      if (init) begin
        base     <= start_addr;
        expected <= span;
        rx_cnt   <= '0;
        wr_cnt   <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
        overflow <= 1'b0;
        if (span != '0) begin
          state <= S_RUN;
          busy  <= 1'b1;
        end else begin
          state    <= S_FIN;
          busy     <= 1'b0;
          complete <= 1'b1;
        end
      end else begin
        case (state)
          S_RUN: begin
            if (push) begin
              wr_ptr <= wr_ptr + PW'(1);
              rx_cnt <= rx_cnt + CW'(1);
            end
            if (pop) begin
              rd_ptr <= rd_ptr + PW'(1);
              wr_cnt <= wr_cnt + CW'(1);
              if ((wr_cnt + CW'(1)) == {1'b0, expected}) begin
                state    <= S_FIN;
                busy     <= 1'b0;
                complete <= 1'b1;
              end
            end
            case ({push, pop})
              2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
              2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
              default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop) begin
              overflow <= 1'b1;
            end
          end
          S_FIN: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
